// File: rtl/demux4_distributor.sv
// 1-to-4 registered distributor: steers each Load word into one of four holding
// registers, addressed by Sel (manual) or by a round-robin pointer (auto).
module demux4_distributor #(
  parameter int W = 2
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [W-1:0] D,
  input  logic [1:0]   Sel,
  input  logic         Load,
  input  logic         Auto,
  input  logic         Clear,
  input  logic [3:0]   Ack,
  output logic [W-1:0] Q0,
  output logic [W-1:0] Q1,
  output logic [W-1:0] Q2,
  output logic [W-1:0] Q3,
  output logic [3:0]   Valid,
  output logic [1:0]   Ptr,
  output logic         Full,
  output logic         Overflow
);

  logic [3:0][W-1:0] q, q_n;
  logic [3:0]        valid_n;
  logic [1:0]        ptr_n;
  logic              ovf_n;
  logic [1:0]        tgt;

  assign tgt = Auto ? Ptr : Sel;

  always_comb begin
    q_n     = q;
    valid_n = Valid & ~Ack;
    ptr_n   = Ptr;
    ovf_n   = Overflow;
    if (Clear) begin
      q_n     = '0;
      valid_n = 4'b0000;
      ptr_n   = 2'd0;
      ovf_n   = 1'b0;
    end else if (Load) begin
      // the auto-mode occupancy check looks at Valid before this cycle's Ack
      if (!Auto || !Valid[tgt]) begin
        q_n[tgt]     = D;
        valid_n[tgt] = 1'b1;
        if (Auto) ptr_n = 2'(Ptr + 2'd1);
      end else begin
        ovf_n = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q        <= '0;
      Valid    <= 4'b0000;
      Ptr      <= 2'd0;
      Overflow <= 1'b0;
    end else begin
      q        <= q_n;
      Valid    <= valid_n;
      Ptr      <= ptr_n;
      Overflow <= ovf_n;
    end
  end

  assign Q0   = q[0];
  assign Q1   = q[1];
  assign Q2   = q[2];
  assign Q3   = q[3];
  assign Full = &Valid;

endmodule

// File: tb/tb_demux4_distributor.sv
// Self-checking bench for demux4_distributor: directed scenarios plus random
// traffic against a channel-level reference model.
module tb_demux4_distributor;
  localparam int W  = 2;
  localparam int PW = 4*W + 8;

  logic         Clock, Resetn;
  logic [W-1:0] D;
  logic [1:0]   Sel;
  logic         Load, Auto, Clear;
  logic [3:0]   Ack;
  logic [W-1:0] Q0, Q1, Q2, Q3;
  logic [3:0]   Valid;
  logic [1:0]   Ptr;
  logic         Full, Overflow;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  int mq[4];
  bit mv[4];
  int mptr;
  bit movf;

  demux4_distributor #(.W(W)) dut (
    .Clock(Clock), .Resetn(Resetn), .D(D), .Sel(Sel), .Load(Load),
    .Auto(Auto), .Clear(Clear), .Ack(Ack), .Q0(Q0), .Q1(Q1), .Q2(Q2),
    .Q3(Q3), .Valid(Valid), .Ptr(Ptr), .Full(Full), .Overflow(Overflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i] = 0;
      mv[i] = 0;
    end
    mptr = 0;
    movf = 0;
  endfunction

  function automatic void model_step(int d, int sel, bit load, bit aut, bit clr, bit [3:0] ack);
    bit pre[4];
    int t;
    if (clr) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      pre[i] = mv[i];
      if (ack[i]) mv[i] = 0;
    end
    if (load) begin
      t = aut ? mptr : sel;
      if (!aut || !pre[t]) begin
        mq[t] = d;
        mv[t] = 1;
        if (aut) mptr = (mptr + 1) % 4;
      end else begin
        movf = 1;
      end
    end
  endfunction

  function automatic logic [PW-1:0] model_pack();
    logic [3:0] v;
    bit all;
    all = 1;
    for (int i = 0; i < 4; i++) begin
      v[i] = mv[i];
      if (!mv[i]) all = 0;
    end
    return {W'(mq[3]), W'(mq[2]), W'(mq[1]), W'(mq[0]), v, 2'(mptr), all, movf};
  endfunction

  function automatic logic [PW-1:0] dut_pack();
    return {Q3, Q2, Q1, Q0, Valid, Ptr, Full, Overflow};
  endfunction

  // one clocked cycle of stimulus; inputs return to idle afterwards
  task automatic apply(int d, int sel, bit load, bit aut, bit clr, bit [3:0] ack);
    D = W'(d); Sel = 2'(sel); Load = load; Auto = aut; Clear = clr; Ack = ack;
    @(posedge Clock);
    #1;
    model_step(d, sel, load, aut, clr, ack);
    Load = 0; Clear = 0; Ack = 4'b0000;
  endtask

  task automatic test_reset();
    Resetn = 0; D = 0; Sel = 0; Load = 0; Auto = 0; Clear = 0; Ack = 0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1;
    vectors++;
    if (dut_pack() !== {PW{1'b0}}) begin
      errors++;
      $display("FAIL reset state: got %h want %h", dut_pack(), {PW{1'b0}});
    end
  endtask

  task automatic test_manual();
    apply(2'b10, 2, 1, 0, 0, 4'b0000);
    vectors++;
    if (Q2 !== 2'b10 || Valid !== 4'b0100 || Ptr !== 2'd0 || Full !== 1'b0) begin
      errors++;
      $display("FAIL manual_load: got Q2=%b Valid=%b Ptr=%0d Full=%b want 10 0100 0 0", Q2, Valid, Ptr, Full);
    end
    apply(0, 0, 0, 0, 1, 4'b0000);
    vectors++;
    if (dut_pack() !== model_pack()) begin
      errors++;
      $display("FAIL manual_clear: got %h want %h", dut_pack(), model_pack());
    end
  endtask

  task automatic test_auto();
    apply(1, 0, 1, 1, 0, 0);
    apply(2, 3, 1, 1, 0, 0);
    apply(3, 1, 1, 1, 0, 0);
    apply(0, 2, 1, 1, 0, 0);
    vectors++;
    if ({Q3, Q2, Q1, Q0} !== {2'd0, 2'd3, 2'd2, 2'd1} || Valid !== 4'b1111 || Full !== 1'b1 || Ptr !== 2'd0) begin
      errors++;
      $display("FAIL auto_fill: got Q=%b%b%b%b Valid=%b Full=%b Ptr=%0d want 00111001 1111 1 0", Q3, Q2, Q1, Q0, Valid, Full, Ptr);
    end
  endtask

  task automatic test_overflow();
    apply(3, 0, 1, 1, 0, 0);
    vectors++;
    if ({Q3, Q2, Q1, Q0} !== 8'b00111001 || Overflow !== 1'b1 || Ptr !== 2'd0) begin
      errors++;
      $display("FAIL overflow_reject: got Q=%b%b%b%b Ovf=%b Ptr=%0d want 00111001 1 0", Q3, Q2, Q1, Q0, Overflow, Ptr);
    end
    apply(0, 0, 0, 1, 0, 4'b0001);
    vectors++;
    if (Valid !== 4'b1110) begin
      errors++;
      $display("FAIL overflow_ack: got Valid=%b want 1110", Valid);
    end
    apply(3, 0, 1, 1, 0, 0);
    vectors++;
    if (Q0 !== 2'd3 || Valid !== 4'b1111 || Ptr !== 2'd1 || Overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_refill: got Q0=%0d Valid=%b Ptr=%0d Ovf=%b want 3 1111 1 1", Q0, Valid, Ptr, Overflow);
    end
    // rejected auto load with simultaneous Ack on the same channel
    apply(0, 0, 1, 1, 0, 4'b0010);
    vectors++;
    if (dut_pack() !== model_pack() || Valid !== 4'b1101 || Q1 !== 2'd2) begin
      errors++;
      $display("FAIL reject_with_ack: got %h want %h", dut_pack(), model_pack());
    end
  endtask

  task automatic test_load_ack();
    apply(0, 0, 0, 0, 1, 0);
    apply(1, 0, 1, 0, 0, 0);
    apply(1, 1, 1, 0, 0, 0);
    apply(2, 1, 1, 0, 0, 4'b0011);
    vectors++;
    if (Valid !== 4'b0010 || Q1 !== 2'd2 || Q0 !== 2'd1) begin
      errors++;
      $display("FAIL load_ack_same: got Valid=%b Q1=%0d Q0=%0d want 0010 2 1", Valid, Q1, Q0);
    end
    apply(3, 1, 1, 0, 0, 0);
    vectors++;
    if (Q1 !== 2'd3 || Valid !== 4'b0010 || Overflow !== 1'b0 || Ptr !== 2'd0) begin
      errors++;
      $display("FAIL manual_overwrite: got Q1=%0d Valid=%b Ovf=%b Ptr=%0d want 3 0010 0 0", Q1, Valid, Overflow, Ptr);
    end
  endtask

  task automatic test_clear();
    apply(2, 0, 1, 1, 0, 0);
    apply(0, 0, 1, 1, 0, 0);
    apply(0, 0, 1, 1, 0, 0);
    apply(3, 2, 1, 0, 1, 4'b1111);
    vectors++;
    if (dut_pack() !== {PW{1'b0}}) begin
      errors++;
      $display("FAIL clear_priority: got %h want %h", dut_pack(), {PW{1'b0}});
    end
  endtask

  task automatic test_async_reset();
    apply(1, 0, 1, 1, 0, 0);
    apply(2, 0, 1, 1, 0, 0);
    apply(3, 0, 1, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 4'b0101);
    apply(2, 3, 1, 0, 0, 0);
    vectors++;
    if (Valid !== 4'b1010 || Ptr !== 2'd3) begin
      errors++;
      $display("FAIL async_setup: got Valid=%b Ptr=%0d want 1010 3", Valid, Ptr);
    end
    #2 Resetn = 0;
    #1;
    model_reset();
    vectors++;
    if (dut_pack() !== {PW{1'b0}}) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", dut_pack(), {PW{1'b0}});
    end
    #1 Resetn = 1;
    apply(3, 2, 1, 1, 0, 0);
    vectors++;
    if (Q0 !== 2'd3 || Valid !== 4'b0001 || Ptr !== 2'd1) begin
      errors++;
      $display("FAIL post_reset_auto: got Q0=%0d Valid=%b Ptr=%0d want 3 0001 1", Q0, Valid, Ptr);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      apply($urandom_range(3), $urandom_range(3), ($urandom_range(3) != 0),
            $urandom_range(1), ($urandom_range(31) == 0),
            4'($urandom) & 4'($urandom));
      vectors++;
      if (dut_pack() !== model_pack()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", n, dut_pack(), model_pack());
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_overflow();
    test_load_ack();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/demux4_distributor.md
Name: demux4_distributor

Overview:
- 1-to-4 registered demultiplexer/distributor; the write-side counterpart of the team's 2-bit 4-to-1 selector datapath.
- Takes one W-bit word per Load strobe and steers it into one of four holding registers Q0..Q3.
- Destination is either an explicit Sel address (manual mode) or an internal round-robin pointer (auto mode).
- Per-channel Valid flags with consumer Ack give a simple load/consume handshake toward downstream selector logic and the LEDR displays.

Parameters:
W, 2, data word width of D and Q0..Q3

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
D  input  W  data word to distribute
Sel  input  2  destination channel in manual mode; ignored in auto mode
Load  input  1  single-cycle write strobe
Auto  input  1  0 = manual addressing, 1 = round-robin addressing via Ptr
Clear  input  1  synchronous clear of flags, pointer and data
Ack  input  4  per-channel consume strobes; Ack[i] clears Valid[i]
Q0, Q1, Q2, Q3  output  W each  channel holding registers
Valid  output  4  Valid[i]=1: Qi holds an unconsumed word
Ptr  output  2  current round-robin pointer
Full  output  1  all four Valid bits set
Overflow  output  1  sticky: auto-mode Load was rejected

Behaviour:
- Clock and reset: one clock, Clock. Resetn is asynchronous and active-low.
- Reset values: Q0..Q3=0, Valid=4'b0000, Ptr=0, Overflow=0, Full=0.
- Outputs: all registered except Full. Full = &Valid, combinational from registered Valid.
- Latency: a Load sampled at edge k is visible on Qi/Valid[i] after edge k; 1 cycle.
- Target channel t: t = Sel when Auto=0; t = Ptr when Auto=1. Auto is sampled in the same cycle as Load.
- Manual Load: Q[t] <= D, Valid[t] <= 1.
  - Overwriting a channel that is still valid is allowed.
  - No flag is set on overwrite. Ptr is unchanged.
- Auto Load, Valid[Ptr]=0: Q[Ptr] <= D, Valid[Ptr] <= 1, Ptr <= Ptr+1 mod 4 (3 wraps to 0).
- Auto Load, Valid[Ptr]=1: the write is rejected. Q and Valid are unchanged, Ptr holds, Overflow <= 1.
- Ack: for each i with Ack[i]=1, Valid[i] <= 0; Qi keeps its data. Multiple Ack bits may be set in one cycle. Ack on an already-invalid channel has no effect.
- Load and Ack to the same channel in the same cycle: Load wins; Valid stays 1 with the new data. The Ack is applied to all other channels.
- Auto-mode Load to channel t with Valid[t]=1 and Ack[t]=1 in the same cycle: treated as a rejected write (flag check uses the pre-edge Valid). Overflow is set and Valid[t] is cleared by the Ack.
- Clear: highest synchronous priority. It sets Q0..Q3=0, Valid=0, Ptr=0, Overflow=0. A Load or Ack in the same cycle is ignored.
- Overflow: cleared only by Clear or reset.
- Mode switch: Ptr is not disturbed by manual-mode activity or by toggling Auto. Auto resumes from the retained Ptr.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of Clock.
- Load deasserted: registers hold; Ack still applies.

Test Plan:
- Reset, then manual Load D=2'b10, Sel=2 -> next cycle Q2=2'b10, Valid=4'b0100, Ptr=0, Full=0.
- Auto=1, four Loads D=1,2,3,0 -> Q0..Q3=1,2,3,0, Valid=4'b1111, Full=1, Ptr wraps to 0.
- From Full, a fifth auto Load D=3 -> Q unchanged, Overflow=1, Ptr=0. Then Ack=4'b0001 -> Valid=4'b1110. Next auto Load D=3 -> Q0=3, Valid=4'b1111, Ptr=1, Overflow remains 1.
- Manual Load Sel=1 D=2 with Ack=4'b0011 in the same cycle (Valid was 4'b0011) -> Valid=4'b0010, Q1=2.
- Clear asserted together with Load -> Q0..Q3=0, Valid=0, Ptr=0, Overflow=0; the Load is dropped.
- Resetn pulsed low between clock edges while Valid=4'b1010 and Ptr=3 -> outputs reach reset values before the next edge. After Resetn rises, an auto Load writes channel 0.
